// File: rtl/serdes_link_tester.sv
// Multi-lane SerDes bring-up pattern generator (training + fixed/counter/PRBS7/external payload) and locking checker.
// Optional macro SERDES_LINK_TESTER_ERR_INJECT_EN adds an inject_err input that flips bit 0 of one payload word.
module serdes_link_tester #(
    parameter int                    LANES         = 1,
    parameter int                    DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 8'hA6,
    parameter int                    TRAIN_CYCLES  = 16,
    parameter int                    LOCK_MATCHES  = 4,
    parameter int                    ERR_CNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [1:0]                     mode,
    input  logic [LANES*DATA_WIDTH-1:0]    ext_data,
    output logic [LANES*DATA_WIDTH-1:0]    tx_data,
    output logic                           tx_training,
    input  logic [LANES*DATA_WIDTH-1:0]    rx_data,
    input  logic [LANES-1:0]               rx_align_done,
    input  logic                           clear_err,
`ifdef SERDES_LINK_TESTER_ERR_INJECT_EN
    input  logic                           inject_err,
`endif
    output logic [LANES-1:0]               lane_locked,
    output logic [LANES-1:0]               err_flag,
    output logic [LANES*ERR_CNT_WIDTH-1:0] err_cnt
);

    localparam int W   = LANES * DATA_WIDTH;
    localparam int TCW = $clog2(TRAIN_CYCLES + 1);
    localparam int LCW = $clog2(LOCK_MATCHES + 1);
    localparam logic [6:0] PRBS_SEED = 7'h7F;

    // Advances the PRBS7 register by one word; returns {next_state, word}, first bit in the MSB.
    function automatic logic [DATA_WIDTH+6:0] prbs_gen(input logic [6:0] s_in);
        logic [6:0]            s;
        logic [DATA_WIDTH-1:0] w;
        logic                  fb;
        s = s_in;
        w = '0;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            fb = s[6] ^ s[5];
            s  = {s[5:0], fb};
            w[DATA_WIDTH-1-k] = fb;
        end
        return {s, w};
    endfunction

    function automatic logic [W-1:0] cnt_seed();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) v[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(i);
        return v;
    endfunction

    typedef enum logic [1:0] {TX_IDLE, TX_TRAIN, TX_PAYLOAD} tx_state_t;
    typedef enum logic [1:0] {RX_HUNT, RX_TRAIN_SEEN, RX_CHECK} rx_state_t;

    tx_state_t              tx_state;
    logic [1:0]             mode_q;
    logic [TCW-1:0]         train_cnt;
    logic [6:0]             tx_prbs;
    logic [W-1:0]           tx_cnt;
    logic [W-1:0]           tx_cnt_inc;
    logic [W-1:0]           tx_payload;
    logic [W-1:0]           inj_mask;
    logic [DATA_WIDTH+6:0]  tx_prbs_nxt;

`ifdef SERDES_LINK_TESTER_ERR_INJECT_EN
    always_comb begin
        inj_mask = '0;
        if (inject_err && tx_state == TX_PAYLOAD) begin
            for (int i = 0; i < LANES; i++) inj_mask[i*DATA_WIDTH] = 1'b1;
        end
    end
`else
    assign inj_mask = '0;
`endif

    assign tx_prbs_nxt = prbs_gen(tx_prbs);

    always_comb begin
        tx_payload = '0;
        tx_cnt_inc = '0;
        for (int i = 0; i < LANES; i++) begin
            tx_cnt_inc[i*DATA_WIDTH +: DATA_WIDTH] = tx_cnt[i*DATA_WIDTH +: DATA_WIDTH] + 1'b1;
            case (mode_q)
                2'b00:   tx_payload[i*DATA_WIDTH +: DATA_WIDTH] = TRAIN_PATTERN;
                2'b01:   tx_payload[i*DATA_WIDTH +: DATA_WIDTH] = tx_cnt[i*DATA_WIDTH +: DATA_WIDTH];
                2'b10:   tx_payload[i*DATA_WIDTH +: DATA_WIDTH] = tx_prbs_nxt[DATA_WIDTH-1:0];
                default: tx_payload[i*DATA_WIDTH +: DATA_WIDTH] = ext_data[i*DATA_WIDTH +: DATA_WIDTH];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state    <= TX_IDLE;
            mode_q      <= 2'b00;
            train_cnt   <= '0;
            tx_prbs     <= PRBS_SEED;
            tx_cnt      <= cnt_seed();
            tx_data     <= '0;
            tx_training <= 1'b0;
        end else if (!enable) begin
            tx_state    <= TX_IDLE;
            train_cnt   <= '0;
            tx_prbs     <= PRBS_SEED;
            tx_cnt      <= cnt_seed();
            tx_data     <= '0;
            tx_training <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    mode_q      <= mode;
                    tx_state    <= TX_TRAIN;
                    tx_data     <= {LANES{TRAIN_PATTERN}};
                    tx_training <= 1'b1;
                    train_cnt   <= TCW'(1);
                end
                TX_TRAIN: begin
                    if (train_cnt == TCW'(TRAIN_CYCLES)) begin
                        tx_state    <= TX_PAYLOAD;
                        tx_training <= 1'b0;
                        tx_data     <= tx_payload;
                        tx_prbs     <= tx_prbs_nxt[DATA_WIDTH+6:DATA_WIDTH];
                        tx_cnt      <= tx_cnt_inc;
                    end else begin
                        tx_data   <= {LANES{TRAIN_PATTERN}};
                        train_cnt <= train_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_data <= tx_payload ^ inj_mask;
                    tx_prbs <= tx_prbs_nxt[DATA_WIDTH+6:DATA_WIDTH];
                    tx_cnt  <= tx_cnt_inc;
                end
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        rx_state_t              rx_state;
        logic [DATA_WIDTH-1:0]  rx_q;
        logic [DATA_WIDTH-1:0]  rx_cnt;
        logic [6:0]             rx_prbs;
        logic [LCW-1:0]         match_cnt;
        logic [ERR_CNT_WIDTH-1:0] cnt;
        logic                   flag;
        logic                   locked;
        logic [DATA_WIDTH+6:0]  rx_prbs_nxt;
        logic [DATA_WIDTH-1:0]  exp_word;
        logic                   active;
        logic                   mismatch;

        assign active      = enable && rx_align_done[i];
        assign rx_prbs_nxt = prbs_gen(rx_prbs);
        assign exp_word    = (mode_q == 2'b01) ? rx_cnt : rx_prbs_nxt[DATA_WIDTH-1:0];

        always_comb begin
            mismatch = 1'b0;
            if (active) begin
                case (rx_state)
                    RX_TRAIN_SEEN: begin
                        if (mode_q == 2'b00)
                            mismatch = (rx_q != TRAIN_PATTERN);
                        else if (mode_q != 2'b11 && rx_q != TRAIN_PATTERN)
                            mismatch = (rx_q != exp_word);
                    end
                    RX_CHECK: mismatch = (mode_q != 2'b11) && (rx_q != exp_word);
                    default:  mismatch = 1'b0;
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) rx_q <= '0;
            else     rx_q <= rx_data[i*DATA_WIDTH +: DATA_WIDTH];
        end

        // Generators stay at seed until the first payload word is seen, then step once per word.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rx_state  <= RX_HUNT;
                locked    <= 1'b0;
                match_cnt <= '0;
                rx_prbs   <= PRBS_SEED;
                rx_cnt    <= DATA_WIDTH'(i);
            end else if (!active) begin
                rx_state  <= RX_HUNT;
                locked    <= 1'b0;
                match_cnt <= '0;
                rx_prbs   <= PRBS_SEED;
                rx_cnt    <= DATA_WIDTH'(i);
            end else begin
                case (rx_state)
                    RX_HUNT: begin
                        rx_prbs <= PRBS_SEED;
                        rx_cnt  <= DATA_WIDTH'(i);
                        if (rx_q == TRAIN_PATTERN) begin
                            if (match_cnt == LCW'(LOCK_MATCHES - 1)) begin
                                rx_state  <= RX_TRAIN_SEEN;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    RX_TRAIN_SEEN: begin
                        if (mode_q != 2'b00 && rx_q != TRAIN_PATTERN) begin
                            rx_state <= RX_CHECK;
                            rx_prbs  <= rx_prbs_nxt[DATA_WIDTH+6:DATA_WIDTH];
                            rx_cnt   <= rx_cnt + 1'b1;
                        end
                    end
                    default: begin
                        rx_prbs <= rx_prbs_nxt[DATA_WIDTH+6:DATA_WIDTH];
                        rx_cnt  <= rx_cnt + 1'b1;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt  <= '0;
                flag <= 1'b0;
            end else if (clear_err) begin
                cnt  <= '0;
                flag <= 1'b0;
            end else if (mismatch) begin
                flag <= 1'b1;
                if (cnt != '1) cnt <= cnt + 1'b1;
            end
        end

        assign lane_locked[i] = locked;
        assign err_flag[i]    = flag;
        assign err_cnt[i*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] = cnt;
    end

endmodule

// File: tb/tb_serdes_link_tester.sv
// Directed loopback bench for serdes_link_tester: TX stream scoreboard plus lock/error-counter checks.
module tb_serdes_link_tester;
    localparam int LANES = 2;
    localparam int DW    = 8;
    localparam int ECW   = 4;
    localparam int W     = LANES * DW;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [W-1:0]     ext_data = '0;
    logic [W-1:0]     tx_data;
    logic             tx_training;
    logic [W-1:0]     rx_data;
    logic [LANES-1:0] rx_align_done = 2'b11;
    logic             clear_err = 1'b0;
    logic [LANES-1:0] lane_locked;
    logic [LANES-1:0] err_flag;
    logic [LANES*ECW-1:0] err_cnt;
    logic             corrupt = 1'b0;
`ifdef SERDES_LINK_TESTER_ERR_INJECT_EN
    logic             inject_err = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    logic [W:0] exp_q[$];
    logic [6:0] m_prbs;

    always #5 clk = ~clk;

    // Loopback with optional inversion of lane 0 to create guaranteed mismatches.
    assign rx_data = {tx_data[W-1:DW], corrupt ? ~tx_data[DW-1:0] : tx_data[DW-1:0]};

    serdes_link_tester #(
        .LANES(LANES), .DATA_WIDTH(DW), .TRAIN_PATTERN(8'hA6),
        .TRAIN_CYCLES(16), .LOCK_MATCHES(4), .ERR_CNT_WIDTH(ECW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .ext_data(ext_data),
        .tx_data(tx_data), .tx_training(tx_training), .rx_data(rx_data),
        .rx_align_done(rx_align_done), .clear_err(clear_err),
`ifdef SERDES_LINK_TESTER_ERR_INJECT_EN
        .inject_err(inject_err),
`endif
        .lane_locked(lane_locked), .err_flag(err_flag), .err_cnt(err_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic prbs_word(output logic [7:0] w);
        logic b;
        for (int k = 7; k >= 0; k--) begin
            b = m_prbs[6] ^ m_prbs[5];
            m_prbs = {m_prbs[5:0], b};
            w[k] = b;
        end
    endtask

    task automatic push_train();
        repeat (16) exp_q.push_back({1'b1, 8'hA6, 8'hA6});
    endtask

    task automatic push_prbs(input int n);
        logic [7:0] w;
        m_prbs = 7'h7F;
        repeat (n) begin
            prbs_word(w);
            exp_q.push_back({1'b0, w, w});
        end
    endtask

    task automatic push_cnt(input int n);
        for (int j = 0; j < n; j++) exp_q.push_back({1'b0, 8'(j + 1), 8'(j)});
    endtask

    task automatic run_sb(input string tag, input int n);
        logic [W:0] exp_v;
        repeat (n) begin
            tick();
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL %s observed=%0h expected=empty_queue", tag, {tx_training, tx_data});
            end else begin
                exp_v = exp_q.pop_front();
                check(tag, 32'({tx_training, tx_data}), 32'(exp_v));
            end
        end
    endtask

    task automatic start(input logic [1:0] m);
        enable = 1'b0;
        mode = m;
        tick();
        enable = 1'b1;
    endtask

    initial begin
        repeat (2) tick();
        check("reset_tx_data", 32'(tx_data), 32'h0);
        check("reset_tx_training", 32'(tx_training), 32'h0);
        check("reset_locked", 32'(lane_locked), 32'h0);
        check("reset_err_flag", 32'(err_flag), 32'h0);
        check("reset_err_cnt", 32'(err_cnt), 32'h0);
        rst = 1'b0;
        tick();

        // PRBS7 loopback; a mode change after the IDLE exit must be ignored.
        start(2'b10);
        push_train();
        push_prbs(40);
        run_sb("prbs_stream", 1);
        mode = 2'b01;
        run_sb("prbs_stream", 4);
        check("prbs_lock_early", 32'(lane_locked), 32'h0);
        run_sb("prbs_stream", 1);
        check("prbs_lock", 32'(lane_locked), 32'h3);
        run_sb("prbs_stream", 50);
        repeat (1000) tick();
        check("prbs_err_cnt_clean", 32'(err_cnt), 32'h0);
        check("prbs_err_flag_clean", 32'(err_flag), 32'h0);
        check("prbs_still_locked", 32'(lane_locked), 32'h3);

        corrupt = 1'b1;
        repeat (3) tick();
        corrupt = 1'b0;
        repeat (3) tick();
        check("corrupt3_err_cnt", 32'(err_cnt), 32'h03);
        check("corrupt3_err_flag", 32'(err_flag), 32'h1);

        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("clear_err_cnt", 32'(err_cnt), 32'h0);
        check("clear_err_flag", 32'(err_flag), 32'h0);

        corrupt = 1'b1;
        tick();
        corrupt = 1'b0;
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        repeat (2) tick();
        check("clear_vs_incr_cnt", 32'(err_cnt), 32'h0);
        check("clear_vs_incr_flag", 32'(err_flag), 32'h0);

        corrupt = 1'b1;
        repeat (20) tick();
        corrupt = 1'b0;
        repeat (3) tick();
        check("saturate_cnt", 32'(err_cnt), 32'h0F);
        check("saturate_flag", 32'(err_flag), 32'h1);

        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        corrupt = 1'b1;
        repeat (2) tick();
        corrupt = 1'b0;
        repeat (2) tick();
        check("pre_drop_cnt", 32'(err_cnt), 32'h02);
        rx_align_done = 2'b10;
        tick();
        check("drop_unlock", 32'(lane_locked), 32'h2);
        corrupt = 1'b1;
        repeat (5) tick();
        corrupt = 1'b0;
        repeat (2) tick();
        check("drop_cnt_held", 32'(err_cnt), 32'h02);
        check("drop_flag_held", 32'(err_flag), 32'h1);
        rx_align_done = 2'b11;
        repeat (10) tick();
        check("no_relock_in_payload", 32'(lane_locked), 32'h2);

        // Counter payload across the 8-bit wrap; re-enable relocks lane 0.
        clear_err = 1'b1;
        start(2'b01);
        clear_err = 1'b0;
        push_train();
        push_cnt(272);
        run_sb("cnt_stream", 5);
        check("cnt_lock_early", 32'(lane_locked), 32'h0);
        run_sb("cnt_stream", 1);
        check("cnt_relock", 32'(lane_locked), 32'h3);
        run_sb("cnt_stream", 282);
        repeat (3) tick();
        check("cnt_err_cnt_clean", 32'(err_cnt), 32'h0);
        check("cnt_err_flag_clean", 32'(err_flag), 32'h0);

        // Fixed mode: checker stays in TRAIN_SEEN, any non-pattern word is an error.
        start(2'b00);
        push_train();
        repeat (10) exp_q.push_back({1'b0, 8'hA6, 8'hA6});
        run_sb("fixed_stream", 26);
        repeat (5) tick();
        check("fixed_locked", 32'(lane_locked), 32'h3);
        check("fixed_err_clean", 32'(err_cnt), 32'h0);
        corrupt = 1'b1;
        tick();
        corrupt = 1'b0;
        repeat (3) tick();
        check("fixed_one_err", 32'(err_cnt), 32'h01);

        // External payload: one-cycle registered path, errors never counted.
        clear_err = 1'b1;
        start(2'b11);
        clear_err = 1'b0;
        push_train();
        run_sb("ext_train", 16);
        repeat (20) begin
            ext_data = W'($urandom_range(0, 65535));
            exp_q.push_back({1'b0, ext_data});
            run_sb("ext_stream", 1);
        end
        corrupt = 1'b1;
        repeat (5) tick();
        corrupt = 1'b0;
        repeat (3) tick();
        check("ext_locked", 32'(lane_locked), 32'h3);
        check("ext_no_errors", 32'(err_cnt), 32'h0);

`ifdef SERDES_LINK_TESTER_ERR_INJECT_EN
        clear_err = 1'b1;
        start(2'b10);
        clear_err = 1'b0;
        repeat (3) tick();
        inject_err = 1'b1;
        tick();
        inject_err = 1'b0;
        repeat (30) tick();
        check("inject_train_ignored", 32'(err_cnt), 32'h0);
        inject_err = 1'b1;
        tick();
        inject_err = 1'b0;
        repeat (4) tick();
        check("inject_one_per_lane", 32'(err_cnt), 32'h11);
        check("inject_flags", 32'(err_flag), 32'h3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serdes_link_tester.md
Name: serdes_link_tester

Overview:
- Parametrised multi-lane test-pattern generator and checker for SerDes link bring-up.
- TX side emits a fixed training word for a set number of cycles, then a selectable payload: fixed, counter, PRBS7 or external data.
- RX side hunts for the training word, locks, regenerates the expected payload locally and counts mismatches per lane.
- Sits between the parallel side of the 8B/10B TX/RX lanes and the system/debug logic, in the parallel-clock domain.

Parameters:
- LANES, 1, number of independent lanes.
- DATA_WIDTH, 8, parallel word width per lane (>=7).
- TRAIN_PATTERN, 8'hA6, training word (DATA_WIDTH bits).
- TRAIN_CYCLES, 16, training words sent after enable (>=1).
- LOCK_MATCHES, 4, consecutive training words required for RX lock (>=1).
- ERR_CNT_WIDTH, 16, per-lane error counter width.

Ports:
- clk  in  1  parallel-word clock.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  run; low returns TX and RX to idle.
- mode  in  2  payload select: 00 fixed, 01 counter, 10 PRBS7, 11 external.
- ext_data  in  LANES*DATA_WIDTH  payload for mode 11.
- tx_data  out  LANES*DATA_WIDTH  words to the serializers; lane i occupies bits [i*DW +: DW].
- tx_training  out  1  high while training words are sent.
- rx_data  in  LANES*DATA_WIDTH  words from the deserializers.
- rx_align_done  in  LANES  per-lane bit alignment complete.
- clear_err  in  1  synchronous clear of error counters and flags.
- lane_locked  out  LANES  checker locked per lane.
- err_flag  out  LANES  sticky mismatch seen per lane.
- err_cnt  out  LANES*ERR_CNT_WIDTH  saturating mismatch count per lane.

Behaviour:
- Reset: tx_data=0, tx_training=0, lane_locked=0, err_flag=0, err_cnt=0, TX FSM=IDLE, RX FSMs=HUNT, generators reseeded.
- TX FSM states: IDLE, TRAIN, PAYLOAD. All outputs are registered.
- IDLE: tx_data=0. At the first edge with enable=1, sample mode into mode_q and go to TRAIN.
- mode_q holds until the next IDLE exit; mode changes at any other time are ignored.
- TRAIN: tx_data=TRAIN_PATTERN on all lanes and tx_training=1 for exactly TRAIN_CYCLES words. Then go to PAYLOAD.
- PAYLOAD word sources per mode_q:
  - 00: TRAIN_PATTERN.
  - 01: lane i counter starts at i, +1 per cycle, wraps mod 2^DW.
  - 10: PRBS7, x^7+x^6+1, seed 7'h7F, fb=s[6]^s[5], s<={s[5:0],fb}, DW bits per word MSB-first, same sequence on all lanes. First word 8'h02, second 8'h0C.
  - 11: ext_data registered, 1-cycle latency.
- enable low in any state: next edge goes to IDLE, tx_data=0, generators reseeded.
- RX FSM per lane, states HUNT, TRAIN_SEEN, CHECK. rx_data is registered once before comparison.
- enable=0 or rx_align_done[i]=0: force HUNT and lane_locked[i]=0. err_cnt and err_flag are held.
- HUNT: count consecutive registered words equal to TRAIN_PATTERN. Any other word resets the count. On reaching LOCK_MATCHES, go to TRAIN_SEEN and set lane_locked[i]=1.
- TRAIN_SEEN, mode_q 00: stays here permanently; every non-pattern word is an error.
- TRAIN_SEEN, other modes: remains while words equal the pattern. The first non-pattern word is the first payload word: compare it against the reseeded local generator's first word and go to CHECK.
- CHECK: compare every word against the local generator, which advances one word per cycle. Mode 11 never counts errors.
- Mismatch: err_cnt[i] +1, saturating at all-ones; err_flag[i]=1 (sticky). err_cnt updates at the second edge after the word is on rx_data.
- clear_err: zeroes err_cnt and err_flag; takes priority over a same-cycle increment. FSM state is unaffected.
- Lock loss (rx_align_done drop): HUNT next edge. Relock needs a fresh training sequence (re-enable).

Optional Feature:
- Macro SERDES_LINK_TESTER_ERR_INJECT_EN.
- With macro: adds input inject_err (1 bit). A pulse seen in PAYLOAD inverts bit 0 of the next tx_data word on every lane, once per pulse; ignored in IDLE/TRAIN.
- Without macro: port absent, no injection logic.

Test Plan:
- Reset, then enable=1 with mode=10 and tx_data looped to rx_data, rx_align_done=all-ones: 16 words of 8'hA6, then 8'h02, 8'h0C, ...; lane_locked=1 after the 4th A6 at RX; err_cnt stays 0 over 1000 cycles.
- Mode 01, LANES=2, loopback: lane0 payload 0,1,2,...,255,0; lane1 payload 1,2,...; wrap produces no error.
- Mode 10 loopback, force rx_data lane0 = 8'hFF for 3 payload cycles: err_cnt[0]=3, err_flag[0]=1, lane1 err_cnt=0. clear_err pulse: both 0; a clear coinciding with a mismatch yields 0.
- ERR_CNT_WIDTH=4, continuous mismatches: err_cnt saturates at 4'hF, no wrap.
- Drop rx_align_done[0] mid-CHECK: lane_locked[0]=0 next edge, err_cnt held; re-enable relocks after 4 training words.
- With SERDES_LINK_TESTER_ERR_INJECT_EN, inject_err pulse in mode 10: exactly 1 error per lane. A pulse during TRAIN adds no error.
